// File: rtl/ddr_rw_scheduler.sv
// Arbitrates one AXI3 master port between a pixel write client and a line read client.
// Optional beat counters are compiled in with `define SCHED_PERF_EN.
//
// state   | meaning
// IDLE    | pick next burst (round-robin when both clients are eligible)
// WR_ADDR | present AW until accepted
// WR_DATA | open the W gate for exactly one burst
// RD_ADDR | present AR until accepted
module ddr_rw_scheduler #(
    parameter int          BURST_LEN   = 16,
    parameter int          BEAT_BYTES  = 8,
    parameter int          FRAME_BYTES = 6220800,
    parameter logic [31:0] WR_BASE     = 32'h0,
    parameter logic [31:0] RD_BASE     = 32'h0,
    parameter int          MAX_RD_OUT  = 4,
    parameter int          MAX_WR_OUT  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_done,
    input  logic [15:0] wr_level,
    input  logic [15:0] rd_space,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,
    output logic        w_en,
    input  logic        wvalid,
    input  logic        wready,
    input  logic        wlast,
    input  logic        bvalid,
    input  logic [1:0]  bresp,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic        rvalid,
    input  logic        rready,
    input  logic        rlast,
    output logic        wr_frame_done,
    output logic        rd_frame_done,
`ifdef SCHED_PERF_EN
    output logic [31:0] wr_beats,
    output logic [31:0] rd_beats,
`endif
    output logic        bresp_err
);

    localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * BEAT_BYTES);
    localparam logic [31:0] WR_END      = WR_BASE + 32'(FRAME_BYTES);
    localparam logic [31:0] RD_END      = RD_BASE + 32'(FRAME_BYTES);
    localparam logic [7:0]  AX_LEN      = 8'(BURST_LEN - 1);
    localparam logic [2:0]  AX_SIZE     = 3'($clog2(BEAT_BYTES));
    localparam logic [1:0]  AX_INCR     = 2'b01;
    localparam logic        GRANT_WR    = 1'b0;
    localparam logic        GRANT_RD    = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WR_ADDR = 2'd1,
        S_WR_DATA = 2'd2,
        S_RD_ADDR = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [31:0] araddr_q, araddr_d;
    logic [3:0]  rd_out_q, rd_out_d;
    logic [3:0]  b_out_q, b_out_d;
    logic        wr_frame_done_q, wr_frame_done_d;
    logic        rd_frame_done_q, rd_frame_done_d;
    logic        bresp_err_q, bresp_err_d;

    logic        wr_elig, rd_elig;
    logic        aw_hs, ar_hs, w_last_hs, r_last_hs;
    logic [31:0] rd_need;
    logic [31:0] aw_next, ar_next;

    // Reads need room for every burst already in flight plus the new one.
    assign rd_need = 32'(BURST_LEN) * (32'(rd_out_q) + 32'd1);
    assign wr_elig = init_done && ({16'b0, wr_level} >= 32'(BURST_LEN))
                     && (b_out_q < 4'(MAX_WR_OUT));
    assign rd_elig = init_done && (rd_out_q < 4'(MAX_RD_OUT))
                     && ({16'b0, rd_space} >= rd_need);

    assign w_last_hs = w_en && wvalid && wready && wlast;
    assign r_last_hs = rvalid && rready && rlast;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        awvalid      = 1'b0;
        arvalid      = 1'b0;
        w_en         = 1'b0;
        aw_hs        = 1'b0;
        ar_hs        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wr_elig && (!rd_elig || last_grant_q == GRANT_RD)) begin
                    state_d      = S_WR_ADDR;
                    last_grant_d = GRANT_WR;
                end else if (rd_elig) begin
                    state_d      = S_RD_ADDR;
                    last_grant_d = GRANT_RD;
                end
            end
            S_WR_ADDR: begin
                awvalid = 1'b1;
                if (awready) begin
                    aw_hs   = 1'b1;
                    state_d = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                w_en = 1'b1;
                if (w_last_hs) state_d = S_IDLE;
            end
            S_RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) begin
                    ar_hs   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outstanding counters: a simultaneous issue and retire cancel out; stray retires at zero are dropped.
    always_comb begin
        rd_out_d = rd_out_q;
        if (ar_hs && !r_last_hs)
            rd_out_d = rd_out_q + 4'd1;
        else if (!ar_hs && r_last_hs && rd_out_q != 4'd0)
            rd_out_d = rd_out_q - 4'd1;

        b_out_d = b_out_q;
        if (aw_hs && !bvalid)
            b_out_d = b_out_q + 4'd1;
        else if (!aw_hs && bvalid && b_out_q != 4'd0)
            b_out_d = b_out_q - 4'd1;

        bresp_err_d = bresp_err_q | (bvalid && bresp != 2'b00);
    end

    always_comb begin
        aw_next         = awaddr_q + BURST_BYTES;
        ar_next         = araddr_q + BURST_BYTES;
        awaddr_d        = awaddr_q;
        araddr_d        = araddr_q;
        wr_frame_done_d = 1'b0;
        rd_frame_done_d = 1'b0;
        if (aw_hs) begin
            if (aw_next >= WR_END) begin
                awaddr_d        = WR_BASE;
                wr_frame_done_d = 1'b1;
            end else begin
                awaddr_d = aw_next;
            end
        end
        if (ar_hs) begin
            if (ar_next >= RD_END) begin
                araddr_d        = RD_BASE;
                rd_frame_done_d = 1'b1;
            end else begin
                araddr_d = ar_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            last_grant_q    <= GRANT_RD;
            awaddr_q        <= WR_BASE;
            araddr_q        <= RD_BASE;
            rd_out_q        <= 4'd0;
            b_out_q         <= 4'd0;
            wr_frame_done_q <= 1'b0;
            rd_frame_done_q <= 1'b0;
            bresp_err_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            awaddr_q        <= awaddr_d;
            araddr_q        <= araddr_d;
            rd_out_q        <= rd_out_d;
            b_out_q         <= b_out_d;
            wr_frame_done_q <= wr_frame_done_d;
            rd_frame_done_q <= rd_frame_done_d;
            bresp_err_q     <= bresp_err_d;
        end
    end

`ifdef SCHED_PERF_EN
    logic [31:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_beats_q, wr_beats_d, rd_beats_q, rd_beats_d;
    logic        wr_beat, rd_beat;

    assign wr_beat = w_en && wvalid && wready;
    assign rd_beat = rvalid && rready;

    // The beat landing in the frame_done cycle belongs to the new frame.
    always_comb begin
        wr_cnt_d   = wr_cnt_q + 32'(wr_beat);
        rd_cnt_d   = rd_cnt_q + 32'(rd_beat);
        wr_beats_d = wr_beats_q;
        rd_beats_d = rd_beats_q;
        if (wr_frame_done_q) begin
            wr_beats_d = wr_cnt_q;
            wr_cnt_d   = 32'(wr_beat);
        end
        if (rd_frame_done_q) begin
            rd_beats_d = rd_cnt_q;
            rd_cnt_d   = 32'(rd_beat);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q   <= 32'd0;
            rd_cnt_q   <= 32'd0;
            wr_beats_q <= 32'd0;
            rd_beats_q <= 32'd0;
        end else begin
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_beats_q <= wr_beats_d;
            rd_beats_q <= rd_beats_d;
        end
    end

    assign wr_beats = wr_beats_q;
    assign rd_beats = rd_beats_q;
`endif

    assign awaddr        = awaddr_q;
    assign araddr        = araddr_q;
    assign awlen         = AX_LEN;
    assign arlen         = AX_LEN;
    assign awsize        = AX_SIZE;
    assign arsize        = AX_SIZE;
    assign awburst       = AX_INCR;
    assign arburst       = AX_INCR;
    assign wr_frame_done = wr_frame_done_q;
    assign rd_frame_done = rd_frame_done_q;
    assign bresp_err     = bresp_err_q;

endmodule
